// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//
// Pipeline hazard controller for the 5-stage RV32I core. It sits beside the
// ID stage and drives the enables of the PC, IF/ID, ID/EX and EX/MEM
// registers. It handles three hazards:
//   - load-use stalls, decoded from the raw ID instruction,
//   - wrong-path squashing for FLUSH_DEPTH cycles after an EX redirect,
//   - a full-pipe freeze while data memory is busy; a redirect that arrives
//     during the freeze is remembered and serviced once memory is free.
//
// Parameters:
//   FLUSH_DEPTH      cycles if_id_flush_o stays high per redirect (1..7)
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_ni           synchronous active-low reset
//   id_valid_i       ID holds a valid instruction
//   id_instr_i[31:0] instruction currently in ID
//   ex_valid_i       EX holds a valid instruction
//   ex_is_load_i     EX instruction is a load
//   ex_rd_i[4:0]     EX destination register
//   ex_redirect_i    one-cycle pulse: taken branch / JAL / JALR in EX
//   mem_busy_i       data memory cannot complete this cycle
//   pc_write_o       PC register enable
//   redirect_take_o  PC mux selects the EX target this cycle
//   if_id_write_o    IF/ID register enable
//   if_id_flush_o    IF/ID loads a NOP/invalid
//   id_ex_bubble_o   ID/EX loads a bubble
//   ex_mem_hold_o    freeze ID/EX and EX/MEM
//   stall_cycles_o   32-bit count of cycles with pc_write_o low
//                    (present only when HAZ_STALL_CNT_EN is defined)
//
// Optional feature macro: HAZ_STALL_CNT_EN

module hazard_control_unit #(
  parameter int unsigned FLUSH_DEPTH = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_valid_i,
  input  logic [31:0] id_instr_i,
  input  logic        ex_valid_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_redirect_i,
  input  logic        mem_busy_i,
  output logic        pc_write_o,
  output logic        redirect_take_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_hold_o
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles_o
`endif
);

  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StFlush = 1'b1;

  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [2:0] FlushReload = 3'(FLUSH_DEPTH - 1);

  logic [0:0] state_q, state_d;
  logic       redirect_pend_q, redirect_pend_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, load_use;
  logic       unused_instr_bits;

  assign opcode = id_instr_i[6:0];
  assign rs1    = id_instr_i[19:15];
  assign rs2    = id_instr_i[24:20];
  assign unused_instr_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};

  // Operand usage follows the same opcode classes as the ID immediate decode.
  // LUI, AUIPC, JAL and unknown opcodes read no registers, so they can never
  // create a load-use hazard.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OpJalr, OpLoad, OpOpImm: uses_rs1 = 1'b1;
      OpBranch, OpStore, OpOp: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 is hardwired to zero, so a load targeting it never produces a hazard.
  assign load_use = ex_valid_i & ex_is_load_i & (ex_rd_i != 5'd0) & id_valid_i &
                    ((uses_rs1 & (rs1 == ex_rd_i)) | (uses_rs2 & (rs2 == ex_rd_i)));

  // Priority chain: reset, memory freeze, redirect (new or pending), flush
  // tail, load-use, normal flow. Freeze wins over a redirect so the redirect
  // is parked in redirect_pend and replayed on the first free cycle. Load-use
  // is only looked at in RUN, since in FLUSH the ID instruction is squashed.
  always_comb begin
    pc_write_o      = 1'b0;
    redirect_take_o = 1'b0;
    if_id_write_o   = 1'b0;
    if_id_flush_o   = 1'b0;
    id_ex_bubble_o  = 1'b0;
    ex_mem_hold_o   = 1'b0;
    state_d         = state_q;
    redirect_pend_d = redirect_pend_q;
    flush_cnt_d     = flush_cnt_q;

    if (!rst_ni) begin
      if_id_flush_o   = 1'b1;
      id_ex_bubble_o  = 1'b1;
      state_d         = StRun;
      redirect_pend_d = 1'b0;
      flush_cnt_d     = 3'd0;
    end else if (mem_busy_i) begin
      ex_mem_hold_o = 1'b1;
      if (ex_redirect_i) begin
        redirect_pend_d = 1'b1;
      end
    end else if (ex_redirect_i || redirect_pend_q) begin
      pc_write_o      = 1'b1;
      redirect_take_o = 1'b1;
      if_id_write_o   = 1'b1;
      if_id_flush_o   = 1'b1;
      id_ex_bubble_o  = 1'b1;
      redirect_pend_d = 1'b0;
      if (FLUSH_DEPTH > 1) begin
        state_d     = StFlush;
        flush_cnt_d = FlushReload;
      end else begin
        state_d     = StRun;
        flush_cnt_d = 3'd0;
      end
    end else if (state_q == StFlush) begin
      pc_write_o     = 1'b1;
      if_id_write_o  = 1'b1;
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
      flush_cnt_d    = flush_cnt_q - 3'd1;
      if (flush_cnt_q == 3'd1) begin
        state_d = StRun;
      end
    end else if (load_use) begin
      id_ex_bubble_o = 1'b1;
    end else begin
      pc_write_o    = 1'b1;
      if_id_write_o = 1'b1;
    end
  end

  // State registers; reset values come from the reset branch above.
  always_ff @(posedge clk_i) begin
    state_q         <= state_d;
    redirect_pend_q <= redirect_pend_d;
    flush_cnt_q     <= flush_cnt_d;
  end

`ifdef HAZ_STALL_CNT_EN
  // Counts every non-reset cycle in which the PC is not advancing, covering
  // both load-use stalls and memory freezes. Wraps naturally at 2^32.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cycles_o <= 32'd0;
    end else if (!pc_write_o) begin
      stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
module tb_hazard_control_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i;
  logic [31:0] id_instr_i;
  logic        ex_valid_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_i;
  logic        ex_redirect_i;
  logic        mem_busy_i;
  logic        pc_write_o;
  logic        redirect_take_o;
  logic        if_id_write_o;
  logic        if_id_flush_o;
  logic        id_ex_bubble_o;
  logic        ex_mem_hold_o;
`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cycles_o;
`endif

  // Expected output vector packing: {pc_write, redirect_take, if_id_write,
  // if_id_flush, id_ex_bubble, ex_mem_hold}
  localparam logic [5:0] ExpRun   = 6'b101000;
  localparam logic [5:0] ExpRst   = 6'b000110;
  localparam logic [5:0] ExpFrz   = 6'b000001;
  localparam logic [5:0] ExpRedir = 6'b111110;
  localparam logic [5:0] ExpFlush = 6'b101110;
  localparam logic [5:0] ExpLuse  = 6'b000010;

  localparam logic [31:0] InstrAdd  = 32'h00728333;
  localparam logic [31:0] InstrLui  = 32'h123452B7;
  localparam logic [31:0] InstrAddi = 32'h00100093;
  localparam logic [31:0] InstrJal  = 32'h0000006F;

  typedef struct {
    string       name;
    logic [5:0]  outs;
    logic [31:0] stall;
    logic        stallKnown;
  } expect_t;

  expect_t sbq[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] expStall = 32'd0;
  logic        stallKnown = 1'b0;

  hazard_control_unit #(.FLUSH_DEPTH(3)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .id_valid_i     (id_valid_i),
    .id_instr_i     (id_instr_i),
    .ex_valid_i     (ex_valid_i),
    .ex_is_load_i   (ex_is_load_i),
    .ex_rd_i        (ex_rd_i),
    .ex_redirect_i  (ex_redirect_i),
    .mem_busy_i     (mem_busy_i),
    .pc_write_o     (pc_write_o),
    .redirect_take_o(redirect_take_o),
    .if_id_write_o  (if_id_write_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_bubble_o (id_ex_bubble_o),
    .ex_mem_hold_o  (ex_mem_hold_o)
`ifdef HAZ_STALL_CNT_EN
    ,
    .stall_cycles_o (stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Drives one cycle of inputs just after the rising edge and queues the
  // hand-computed output vector for that cycle. The stall-counter expectation
  // is the count of non-reset stall cycles seen before this one.
  task automatic applyStimulus(input string name, input logic rst, input logic idv,
                               input logic [31:0] instr, input logic exv,
                               input logic ld, input logic [4:0] rd,
                               input logic redir, input logic busy,
                               input logic [5:0] exp);
    expect_t e;
    @(posedge clk_i);
    #1;
    rst_ni        = rst;
    id_valid_i    = idv;
    id_instr_i    = instr;
    ex_valid_i    = exv;
    ex_is_load_i  = ld;
    ex_rd_i       = rd;
    ex_redirect_i = redir;
    mem_busy_i    = busy;
    e.name       = name;
    e.outs       = exp;
    e.stall      = expStall;
    e.stallKnown = stallKnown;
    sbq.push_back(e);
    if (!rst) begin
      expStall   = 32'd0;
      stallKnown = 1'b1;
    end else if (!exp[5]) begin
      expStall = expStall + 32'd1;
    end
  endtask

  // Compares one scoreboard entry against the live DUT outputs.
  task automatic checkOutput(input expect_t e);
    logic [5:0] got;
    got = {pc_write_o, redirect_take_o, if_id_write_o, if_id_flush_o,
           id_ex_bubble_o, ex_mem_hold_o};
    checks++;
    if (got !== e.outs) begin
      errors++;
      $display("[TB] FAIL %s outputs got %b expected %b", e.name, got, e.outs);
    end
`ifdef HAZ_STALL_CNT_EN
    if (e.stallKnown) begin
      checks++;
      if (stall_cycles_o !== e.stall) begin
        errors++;
        $display("[TB] FAIL %s stall_cycles got %0d expected %0d", e.name,
                 stall_cycles_o, e.stall);
      end
    end
`endif
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response;
  // sample mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (sbq.size() > 0) begin
        checkOutput(sbq.pop_front());
      end
    end
  end

  initial begin
    rst_ni        = 1'b0;
    id_valid_i    = 1'b0;
    id_instr_i    = 32'd0;
    ex_valid_i    = 1'b0;
    ex_is_load_i  = 1'b0;
    ex_rd_i       = 5'd0;
    ex_redirect_i = 1'b0;
    mem_busy_i    = 1'b0;

    //            name            rst idv instr      exv ld rd    rdr bsy expected
    applyStimulus("reset",        0, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRst);
    applyStimulus("idle",         1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("loaduse_rs1",  1, 1, InstrAdd,  1, 1, 5'd5, 0, 0, ExpLuse);
    applyStimulus("after_bubble", 1, 1, InstrAdd,  0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("lui_no_stall", 1, 1, InstrLui,  1, 1, 5'd5, 0, 0, ExpRun);
    applyStimulus("rd0_no_stall", 1, 1, InstrAddi, 1, 1, 5'd0, 0, 0, ExpRun);
    applyStimulus("loaduse_rs2",  1, 1, InstrAdd,  1, 1, 5'd7, 0, 0, ExpLuse);
    applyStimulus("jal_no_stall", 1, 1, InstrJal,  1, 1, 5'd0, 0, 0, ExpRun);
    applyStimulus("not_load",     1, 1, InstrAdd,  1, 0, 5'd5, 0, 0, ExpRun);
    applyStimulus("id_invalid",   1, 0, InstrAdd,  1, 1, 5'd5, 0, 0, ExpRun);
    applyStimulus("redirect",     1, 0, 32'd0,     0, 0, 5'd0, 1, 0, ExpRedir);
    applyStimulus("flush_1",      1, 1, InstrAdd,  1, 1, 5'd5, 0, 0, ExpFlush);
    applyStimulus("flush_2",      1, 1, InstrAdd,  1, 1, 5'd5, 0, 0, ExpFlush);
    applyStimulus("flush_done",   1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("freeze_1",     1, 0, 32'd0,     0, 0, 5'd0, 0, 1, ExpFrz);
    applyStimulus("freeze_redir", 1, 0, 32'd0,     0, 0, 5'd0, 1, 1, ExpFrz);
    applyStimulus("freeze_merge", 1, 0, 32'd0,     0, 0, 5'd0, 1, 1, ExpFrz);
    applyStimulus("pend_taken",   1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRedir);
    applyStimulus("pflush_1",     1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("pflush_2",     1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("pend_cleared", 1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("redir_b",      1, 0, 32'd0,     0, 0, 5'd0, 1, 0, ExpRedir);
    applyStimulus("bflush_1",     1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("bflush_busy",  1, 0, 32'd0,     0, 0, 5'd0, 0, 1, ExpFrz);
    applyStimulus("bflush_2",     1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("bflush_done",  1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("redir_c",      1, 0, 32'd0,     0, 0, 5'd0, 1, 0, ExpRedir);
    applyStimulus("cflush_1",     1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("redir_in_fl",  1, 0, 32'd0,     0, 0, 5'd0, 1, 0, ExpRedir);
    applyStimulus("cflush_r1",    1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("cflush_r2",    1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpFlush);
    applyStimulus("cflush_done",  1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("redir_d",      1, 0, 32'd0,     0, 0, 5'd0, 1, 0, ExpRedir);
    applyStimulus("rst_in_flush", 0, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRst);
    applyStimulus("run_after_rst",1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("busy_load",    1, 1, InstrAdd,  1, 1, 5'd5, 0, 1, ExpFrz);
    applyStimulus("freeze_pend",  1, 0, 32'd0,     0, 0, 5'd0, 1, 1, ExpFrz);
    applyStimulus("rst_pend",     0, 0, 32'd0,     0, 0, 5'd0, 0, 1, ExpRst);
    applyStimulus("pend_dropped", 1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);
    applyStimulus("final_idle",   1, 0, 32'd0,     0, 0, 5'd0, 0, 0, ExpRun);

    // Give the monitor a bounded number of cycles to drain the scoreboard.
    for (int i = 0; i < 5 && sbq.size() > 0; i++) begin
      @(negedge clk_i);
    end
    @(negedge clk_i);
    if (sbq.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain pending got %0d expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
